soc_test_controller: RTL and testbench

Parametrised, synthesizable test-run controller for the rv32i_soc simulation and FPGA bring-up flow. It sequences the core reset, snoops the data-side Wishbone bus for a `tohost` exit write, and enforces a cycle-timeout watchdog. When the run ends, it walks a memory read port to stream out a signature of `DUMP_WORDS` words. It sits beside `rv32i_soc` and replaces the fixed-length reset, fixed-length run and dump sequence of the current bench with a single reusable block.

---
 rtl/soc_tb_pkg.sv | 17 +
 rtl/soc_test_controller.sv | 120 ++++++++++++
 tb/tb_soc_test_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/soc_tb_pkg.sv
// Shared types and constants for the SoC test-run controller.
package soc_tb_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    DUMP       = 2'd2,
    DONE       = 2'd3
  } tc_state_e;

  // Bit of the tohost write data that marks an exit request.
  localparam int TOHOST_EXIT_BIT = 0;

  // Default byte address of the tohost exit register.
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/soc_test_controller.sv
// Test-run controller: holds the core in reset, runs it until a tohost exit
// write or a watchdog timeout, then streams a DUMP_WORDS signature.
module soc_test_controller
  import soc_tb_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                RESET_CYCLES   = 2,
  parameter int                TIMEOUT_CYCLES = 10000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT),
  parameter int                DUMP_WORDS     = 100,
  parameter int                DUMP_AW        = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1,
  parameter int                CNT_W          = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic               i_wb_ack,
  input  logic [ADDR_W-1:0]  i_wb_adr,
  input  logic [DATA_W-1:0]  i_wb_dat,
  output logic               o_core_reset_n,
  output logic               o_dump_en,
  output logic [DUMP_AW-1:0] o_dump_addr,
  input  logic [DATA_W-1:0]  i_dump_data,
  output logic               o_dump_valid,
  output logic [DUMP_AW-1:0] o_dump_index,
  output logic [DATA_W-1:0]  o_dump_data,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [DATA_W-2:0]  o_exit_code,
  output logic [CNT_W-1:0]   o_cycle_count
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  // One extra bit so the counter can reach DUMP_WORDS even when it is a power of two.
  localparam int DCNT_W = DUMP_AW + 1;

  tc_state_e         state, state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DCNT_W-1:0] dump_cnt;
  logic              hold_last, exit_wr, expire, run_end, dump_last;

  assign hold_last = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
  assign exit_wr   = (state == RUN) && i_wb_cyc && i_wb_stb && i_wb_we && i_wb_ack &&
                     (i_wb_adr == TOHOST_ADDR) && i_wb_dat[TOHOST_EXIT_BIT];
  assign expire    = (state == RUN) && (o_cycle_count == CNT_W'(TIMEOUT_CYCLES));
  assign run_end   = exit_wr || expire;
  // DUMP lasts DUMP_WORDS+1 cycles: the extra one lets the last read word come back.
  assign dump_last = (dump_cnt == DCNT_W'(DUMP_WORDS));

  assign o_dump_en   = (state == DUMP) && !dump_last;
  assign o_dump_addr = dump_cnt[DUMP_AW-1:0];
  assign o_done      = (state == DONE);
  assign o_dump_data = o_dump_valid ? i_dump_data : '0;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RESET_HOLD;
    else          state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      RESET_HOLD: if (hold_last) state_next = RUN;
      RUN:        if (run_end)   state_next = (DUMP_WORDS == 0) ? DONE : DUMP;
      DUMP:       if (dump_last) state_next = DONE;
      default:    state_next = state;
    endcase
  end

  // Core reset is a flop so it never glitches; hold and run counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_core_reset_n <= 1'b0;
      hold_cnt       <= '0;
      o_cycle_count  <= '0;
    end else begin
      o_core_reset_n <= (state_next == RUN);
      if (state == RESET_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == RESET_HOLD && hold_last)
        o_cycle_count <= CNT_W'(1);
      else if (state == RUN && !run_end)
        o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

  // Sticky run result; an exit write beats a same-cycle timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_pass      <= 1'b0;
      o_timeout   <= 1'b0;
      o_exit_code <= '0;
    end else if (exit_wr) begin
      o_exit_code <= i_wb_dat[DATA_W-1:1];
      o_pass      <= (i_wb_dat[DATA_W-1:1] == '0);
    end else if (expire) begin
      o_timeout   <= 1'b1;
      o_pass      <= 1'b0;
    end
  end

  // Dump address walk and one-cycle-delayed valid/index for the returned word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dump_cnt     <= '0;
      o_dump_valid <= 1'b0;
      o_dump_index <= '0;
    end else begin
      if (o_dump_en) dump_cnt <= dump_cnt + 1'b1;
      o_dump_valid <= o_dump_en;
      o_dump_index <= o_dump_addr;
    end
  end

endmodule

// File: tb/tb_soc_test_controller.sv
// Bench for soc_test_controller: two instances share one snooped bus,
// A (timeout 60, 4-word dump) and B (timeout 20, empty dump).
module tb_soc_test_controller;
  localparam int TA = 60, WA = 4, TB = 20, WB = 0, NCYC = 68;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic clk = 1'b0, reset_n = 1'b0;
  logic wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr, wb_dat;

  logic a_core, a_den, a_dv, a_done, a_pass, a_to;
  logic [1:0] a_dad, a_di;
  logic [31:0] a_dd, a_cnt, a_mem;
  logic [30:0] a_ec;
  logic b_core, b_den, b_dv, b_done, b_pass, b_to;
  logic [0:0] b_dad, b_di;
  logic [31:0] b_dd, b_cnt, b_mem;
  logic [30:0] b_ec;

  int n_cmp = 0, n_bad = 0;

  // Per-RUN-cycle bus activity: flags = {cyc, stb, we, ack}.
  logic [3:0]  bflg [1:NCYC];
  logic [31:0] badr [1:NCYC];
  logic [31:0] bdat [1:NCYC];

  typedef struct {
    string nm;
    int c1; logic [31:0] a1, d1;
    int c2; logic [31:0] a2, d2;
    int eA; bit pA; logic [30:0] xA; bit tA;
    int eB; bit pB; logic [30:0] xB; bit tB;
    bit ab;
  } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  // Memory model: word at address a reads back as a*16+5 one cycle later.
  always @(posedge clk) a_mem <= 32'(a_dad) * 32'd16 + 32'd5;
  assign b_mem = 32'hDEAD_BEEF;

  soc_test_controller #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(TA), .DUMP_WORDS(WA)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_ack(wb_ack),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .o_core_reset_n(a_core), .o_dump_en(a_den), .o_dump_addr(a_dad), .i_dump_data(a_mem),
    .o_dump_valid(a_dv), .o_dump_index(a_di), .o_dump_data(a_dd), .o_done(a_done),
    .o_pass(a_pass), .o_timeout(a_to), .o_exit_code(a_ec), .o_cycle_count(a_cnt));

  soc_test_controller #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(TB), .DUMP_WORDS(WB)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_ack(wb_ack),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .o_core_reset_n(b_core), .o_dump_en(b_den), .o_dump_addr(b_dad), .i_dump_data(b_mem),
    .o_dump_valid(b_dv), .o_dump_index(b_di), .o_dump_data(b_dd), .o_done(b_done),
    .o_pass(b_pass), .o_timeout(b_to), .o_exit_code(b_ec), .o_cycle_count(b_cnt));

  task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int c1, input logic [31:0] a1, d1,
                              input int c2, input logic [31:0] a2, d2,
                              input int eA, input bit pA, input logic [30:0] xA, input bit tA,
                              input int eB, input bit pB, input logic [30:0] xB, input bit tB,
                              input bit ab);
    vec_t v;
    v.nm = nm; v.c1 = c1; v.a1 = a1; v.d1 = d1; v.c2 = c2; v.a2 = a2; v.d2 = d2;
    v.eA = eA; v.pA = pA; v.xA = xA; v.tA = tA;
    v.eB = eB; v.pB = pB; v.xB = xB; v.tB = tB; v.ab = ab;
    return v;
  endfunction

  task automatic clear_bus();
    for (int t = 1; t <= NCYC; t++) begin bflg[t] = 4'h0; badr[t] = '0; bdat[t] = '0; end
  endtask

  task automatic drive(input int t);
    {wb_cyc, wb_stb, wb_we, wb_ack} = bflg[t];
    wb_adr = badr[t];
    wb_dat = bdat[t];
  endtask

  // Reference: the run ends at the first complete, bit0-set tohost write within
  // the timeout window, otherwise by timeout at cycle T.
  function automatic void model(input int T, output int e, output bit p,
                                output logic [30:0] x, output bit to);
    e = T; p = 1'b0; x = '0; to = 1'b1;
    for (int t = 1; t <= T; t++)
      if (bflg[t] == 4'hF && badr[t] == TOHOST && bdat[t][0]) begin
        e = t; x = bdat[t][31:1]; p = (x == 0); to = 1'b0;
        break;
      end
  endfunction

  // Expected outputs of one instance in RUN-relative cycle t, given the run end E.
  task automatic check_inst(input string n, input int t, input int E, input int W,
                            input bit p, input logic [30:0] x, input bit to,
                            input logic core, input logic [31:0] cnt, input logic den,
                            input logic [1:0] dad, input logic dv, input logic [1:0] di,
                            input logic [31:0] dd, input logic done, input logic pass,
                            input logic tmo, input logic [30:0] ec);
    bit run, ven, vv;
    run = (t <= E);
    ven = (t > E) && (t <= E + W);
    vv  = (t > E + 1) && (t <= E + W + 1);
    chk({n, ".core_reset_n"}, t, 64'(core), 64'(run));
    chk({n, ".cycle_count"}, t, 64'(cnt), 64'(run ? t : E));
    chk({n, ".dump_en"}, t, 64'(den), 64'(ven));
    if (ven) chk({n, ".dump_addr"}, t, 64'(dad), 64'(t - E - 1));
    chk({n, ".dump_valid"}, t, 64'(dv), 64'(vv));
    if (vv) begin
      chk({n, ".dump_index"}, t, 64'(di), 64'(t - E - 2));
      chk({n, ".dump_data"}, t, 64'(dd), 64'((t - E - 2) * 16 + 5));
    end else chk({n, ".dump_data_idle"}, t, 64'(dd), 64'(0));
    chk({n, ".done"}, t, 64'(done), 64'(t >= E + W + 1 + ((W > 0) ? 1 : 0)));
    chk({n, ".pass"}, t, 64'(pass), 64'(!run && p));
    chk({n, ".timeout"}, t, 64'(tmo), 64'(!run && to));
    chk({n, ".exit_code"}, t, 64'(ec), run ? 64'(0) : 64'(x));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".rstA_ctl"}, 0, 64'({a_core, a_den, a_dad, a_dv, a_di, a_done, a_pass, a_to}), 64'(0));
    chk({nm, ".rstA_dat"}, 0, {a_dd, a_cnt}, 64'(0));
    chk({nm, ".rstA_ec"}, 0, 64'(a_ec), 64'(0));
    chk({nm, ".rstB_ctl"}, 0, 64'({b_core, b_den, b_dad, b_dv, b_di, b_done, b_pass, b_to}), 64'(0));
    chk({nm, ".rstB_dat"}, 0, {b_dd, b_cnt}, 64'(0));
    chk({nm, ".rstB_ec"}, 0, 64'(b_ec), 64'(0));
  endtask

  task automatic run_case(input string nm, input int eA, input bit pA, input logic [30:0] xA,
                          input bit tA, input int eB, input bit pB, input logic [30:0] xB,
                          input bit tB, input bit ab);
    reset_n = 1'b0;
    drive(1);
    {wb_cyc, wb_stb, wb_we, wb_ack} = 4'h0;
    @(posedge clk); #1;
    chk_reset(nm);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk({nm, ".hold"}, 0, 64'({a_core, b_core}), 64'(0));
    @(posedge clk); #1;
    for (int t = 1; t <= NCYC; t++) begin
      drive(t);
      check_inst({nm, ".A"}, t, eA, WA, pA, xA, tA, a_core, a_cnt, a_den, a_dad, a_dv, a_di,
                 a_dd, a_done, a_pass, a_to, a_ec);
      check_inst({nm, ".B"}, t, eB, WB, pB, xB, tB, b_core, b_cnt, b_den, {1'b0, b_dad}, b_dv,
                 {1'b0, b_di}, b_dd, b_done, b_pass, b_to, b_ec);
      if (ab && t == eA + 3) begin
        // Reset lands mid-dump while A presents address 2.
        reset_n = 1'b0;
        #1;
        chk_reset({nm, ".abort"});
        {wb_cyc, wb_stb, wb_we, wb_ack} = 4'h0;
        return;
      end
      @(posedge clk); #1;
    end
    {wb_cyc, wb_stb, wb_we, wb_ack} = 4'h0;
  endtask

  initial begin
    int eA, eB;
    bit pA, pB, tA, tB;
    logic [30:0] xA, xB;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_ack = 0; wb_adr = '0; wb_dat = '0;

    vecs[0] = mk("pass50", 50, TOHOST, 32'h1, 0, 0, 0, 50, 1, 0, 0, 20, 0, 0, 1, 0);
    vecs[1] = mk("fail7", 10, TOHOST, 32'h2, 30, TOHOST, 32'h7, 30, 0, 3, 0, 20, 0, 0, 1, 0);
    vecs[2] = mk("collA", 60, TOHOST, 32'h9, 0, 0, 0, 60, 0, 4, 0, 20, 0, 0, 1, 0);
    vecs[3] = mk("collB", 20, TOHOST, 32'h1, 0, 0, 0, 20, 1, 0, 0, 20, 1, 0, 0, 0);
    vecs[4] = mk("early", 5, TOHOST, 32'hB, 0, 0, 0, 5, 0, 5, 0, 5, 0, 5, 0, 0);
    vecs[5] = mk("tmo", 0, 0, 0, 0, 0, 0, 60, 0, 0, 1, 20, 0, 0, 1, 0);
    vecs[6] = mk("badadr", 15, 32'h1004, 32'h1, 16, TOHOST, 32'h4, 60, 0, 0, 1, 20, 0, 0, 1, 0);
    vecs[7] = mk("abort", 8, TOHOST, 32'h1, 0, 0, 0, 8, 1, 0, 0, 8, 1, 0, 0, 1);
    vecs[8] = mk("rerun", 8, TOHOST, 32'h1, 0, 0, 0, 8, 1, 0, 0, 8, 1, 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      clear_bus();
      if (vecs[i].c1 > 0) begin
        bflg[vecs[i].c1] = 4'hF; badr[vecs[i].c1] = vecs[i].a1; bdat[vecs[i].c1] = vecs[i].d1;
      end
      if (vecs[i].c2 > 0) begin
        bflg[vecs[i].c2] = 4'hF; badr[vecs[i].c2] = vecs[i].a2; bdat[vecs[i].c2] = vecs[i].d2;
      end
      run_case(vecs[i].nm, vecs[i].eA, vecs[i].pA, vecs[i].xA, vecs[i].tA,
               vecs[i].eB, vecs[i].pB, vecs[i].xB, vecs[i].tB, vecs[i].ab);
    end

    for (int r = 0; r < 25; r++) begin
      clear_bus();
      for (int t = 1; t <= NCYC; t++) begin
        if ($urandom_range(0, 7) == 0) begin
          bflg[t] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          badr[t] = $urandom_range(0, 1) ? TOHOST : ($urandom_range(0, 1) ? 32'h1004 : $urandom);
          bdat[t] = $urandom_range(0, 1) ? 32'($urandom_range(0, 1)) : $urandom;
        end else begin
          bflg[t] = 4'($urandom_range(0, 7));
          badr[t] = $urandom;
          bdat[t] = $urandom;
        end
      end
      model(TA, eA, pA, xA, tA);
      model(TB, eB, pB, xB, tB);
      run_case($sformatf("rnd%0d", r), eA, pA, xA, tA, eB, pB, xB, tB, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
